// File: rtl/seg7_scan_if.sv
// Display readback bus: multiplexed segment/digit-select inputs plus the
// valid/ready frame hand-off toward the consumer.
`timescale 1ns/1ps
interface seg7_scan_if #(
    parameter int NDIGITS = 4
);
    logic [6:0]           seg_in;
    logic [NDIGITS-1:0]   dig_sel;
    logic [4*NDIGITS-1:0] frame_bcd;
    logic [NDIGITS-1:0]   frame_err;
    logic                 frame_valid;
    logic                 frame_ready;
    logic                 overrun;

    modport master (
        output seg_in, dig_sel, frame_ready,
        input  frame_bcd, frame_err, frame_valid, overrun
    );

    modport slave (
        input  seg_in, dig_sel, frame_ready,
        output frame_bcd, frame_err, frame_valid, overrun
    );
endinterface

// File: rtl/seg7_scan_reader.sv
// Reconstructs BCD digits from a scanned 7-segment bus: debounces each slot,
// decodes A..G patterns, assembles full frames and hands them off valid/ready.
//
// state | meaning
// EMPTY | no frame held, frame_valid low
// FULL  | frame held in output regs, waiting for frame_ready
`timescale 1ns/1ps
module seg7_scan_reader #(
    parameter int NDIGITS       = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    seg7_scan_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0]      CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]      CNT_ARM = CW'(STABLE_CYCLES - 2);
    localparam logic [NDIGITS-1:0] SEL_ONE = NDIGITS'(1);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t               state, state_next;
    logic [6:0]           seg_q;
    logic [NDIGITS-1:0]   sel_q;
    logic [CW-1:0]        cnt, cnt_next;
    logic                 same, sel_onehot, capture, complete, load, ovr_next;
    logic [4:0]           dec;
    logic [NDIGITS-1:0]   mask, mask_next;
    logic [4*NDIGITS-1:0] work_bcd, work_bcd_next;
    logic [NDIGITS-1:0]   work_err, work_err_next;
    logic [4*NDIGITS-1:0] frame_bcd_q;
    logic [NDIGITS-1:0]   frame_err_q;
    logic                 overrun_q;

    // Returns {err, nibble}; unknown patterns read back as 4'hF with err set.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b1111110: decode = 5'h00;
            7'b0110000: decode = 5'h01;
            7'b1101101: decode = 5'h02;
            7'b1111001: decode = 5'h03;
            7'b0110011: decode = 5'h04;
            7'b1011011: decode = 5'h05;
            7'b1011111: decode = 5'h06;
            7'b1110000: decode = 5'h07;
            7'b1111111: decode = 5'h08;
            7'b1110011: decode = 5'h09;
            default:    decode = 5'h1F;
        endcase
    endfunction

    always_comb begin
        same       = (bus.seg_in == seg_q) && (bus.dig_sel == sel_q);
        sel_onehot = (sel_q != '0) && ((sel_q & (sel_q - SEL_ONE)) == '0);
        cnt_next   = '0;
        if (same)
            cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        // Fires only on the arm->max step, so a held pattern is taken once.
        capture    = same && (cnt == CNT_ARM) && sel_onehot;
        dec        = decode(seg_q);
    end

    always_comb begin
        work_bcd_next = work_bcd;
        work_err_next = work_err;
        mask_next     = mask;
        if (capture) begin
            for (int i = 0; i < NDIGITS; i++) begin
                if (sel_q[i]) begin
                    work_bcd_next[4*i +: 4] = dec[3:0];
                    work_err_next[i]        = dec[4];
                    mask_next[i]            = 1'b1;
                end
            end
        end
        complete = capture && (&mask_next);
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        ovr_next   = 1'b0;
        case (state)
            EMPTY: begin
                if (complete) begin
                    load       = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (bus.frame_ready) begin
                    if (complete)
                        load = 1'b1;
                    else
                        state_next = EMPTY;
                end else if (complete) begin
                    ovr_next = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q       <= '0;
            sel_q       <= '0;
            cnt         <= '0;
            mask        <= '0;
            work_bcd    <= '0;
            work_err    <= '0;
            state       <= EMPTY;
            frame_bcd_q <= '0;
            frame_err_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            seg_q     <= bus.seg_in;
            sel_q     <= bus.dig_sel;
            cnt       <= cnt_next;
            mask      <= complete ? '0 : mask_next;
            work_bcd  <= work_bcd_next;
            work_err  <= work_err_next;
            state     <= state_next;
            overrun_q <= ovr_next;
            if (load) begin
                frame_bcd_q <= work_bcd_next;
                frame_err_q <= work_err_next;
            end
        end
    end

    assign bus.frame_bcd   = frame_bcd_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.frame_valid = (state == FULL);
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader: scans hand-built frames and compares
// delivered frames, flags and overrun pulses against hand-computed values.
`timescale 1ns/1ps
module tb_seg7_scan_reader;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   ovr_cnt  = 0;
    int   vld_cnt  = 0;
    logic [15:0] q_bcd[$];
    logic [3:0]  q_err[$];

    seg7_scan_if #(.NDIGITS(4)) bus();

    seg7_scan_reader #(.NDIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // frame_ready changes just after posedge, so negedge sees what the next edge uses
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.frame_valid) vld_cnt++;
            if (bus.overrun) ovr_cnt++;
            if (bus.frame_valid && bus.frame_ready) begin
                q_bcd.push_back(bus.frame_bcd);
                q_err.push_back(bus.frame_err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: seg_of = 7'b1111110;
            4'd1: seg_of = 7'b0110000;
            4'd2: seg_of = 7'b1101101;
            4'd3: seg_of = 7'b1111001;
            4'd4: seg_of = 7'b0110011;
            4'd5: seg_of = 7'b1011011;
            4'd6: seg_of = 7'b1011111;
            4'd7: seg_of = 7'b1110000;
            4'd8: seg_of = 7'b1111111;
            4'd9: seg_of = 7'b1110011;
            default: seg_of = 7'b0000001;
        endcase
    endfunction

    task automatic show(input logic [3:0] sel, input logic [6:0] p, input int n);
        bus.dig_sel = sel;
        bus.seg_in  = p;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic scan_frame(input logic [15:0] digits);
        for (int i = 0; i < 4; i++)
            show(4'(1 << i), seg_of(digits[4*i +: 4]), 5);
    endtask

    task automatic take_frame(input string tag, input logic [15:0] eb, input logic [3:0] ee);
        chk({tag, "_count"}, q_bcd.size(), 1);
        if (q_bcd.size() > 0) begin
            chk({tag, "_bcd"}, q_bcd.pop_front(), eb);
            chk({tag, "_err"}, q_err.pop_front(), ee);
        end
    endtask

    initial begin
        int ovr0;
        rst_n           = 1'b0;
        bus.seg_in      = '0;
        bus.dig_sel     = '0;
        bus.frame_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bcd", bus.frame_bcd, 0);
        chk("rst_err", bus.frame_err, 0);
        chk("rst_valid", bus.frame_valid, 0);
        chk("rst_overrun", bus.overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_valid", bus.frame_valid, 0);

        // clean scan: valid must rise right after the 4th sample of slot3
        bus.frame_ready = 1'b1;
        vld_cnt = 0;
        show(4'b0001, seg_of(4'd1), 5);
        show(4'b0010, seg_of(4'd2), 5);
        show(4'b0100, seg_of(4'd3), 5);
        show(4'b1000, seg_of(4'd4), 3);
        chk("clean_valid_early", bus.frame_valid, 0);
        show(4'b1000, seg_of(4'd4), 1);
        chk("clean_valid_rise", bus.frame_valid, 1);
        chk("clean_bcd_live", bus.frame_bcd, 16'h4321);
        show(4'b1000, seg_of(4'd4), 1);
        chk("clean_valid_drop", bus.frame_valid, 0);
        chk("clean_valid_cycles", vld_cnt, 1);
        take_frame("clean", 16'h4321, 4'b0000);

        // glitch: a 6 held only three samples on slot0 must not land
        show(4'b0001, seg_of(4'd6), 3);
        show(4'b0001, seg_of(4'd0), 5);
        show(4'b0010, seg_of(4'd7), 5);
        show(4'b0100, seg_of(4'd8), 5);
        show(4'b1000, seg_of(4'd9), 5);
        take_frame("glitch", 16'h9870, 4'b0000);

        show(4'b0001, seg_of(4'd9), 5);
        show(4'b0010, seg_of(4'd8), 5);
        show(4'b0100, 7'b0000001, 5);
        show(4'b1000, seg_of(4'd5), 5);
        take_frame("invalid", 16'h5F89, 4'b0100);

        // backpressure: second frame is dropped, first is held
        bus.frame_ready = 1'b0;
        ovr0 = ovr_cnt;
        scan_frame(16'h4321);
        chk("bp_valid", bus.frame_valid, 1);
        scan_frame(16'h5678);
        chk("bp_hold_bcd", bus.frame_bcd, 16'h4321);
        chk("bp_hold_err", bus.frame_err, 0);
        chk("bp_overrun", ovr_cnt - ovr0, 1);
        bus.frame_ready = 1'b1;
        show(4'b1000, seg_of(4'd5), 1);
        chk("bp_released", bus.frame_valid, 0);
        take_frame("bp", 16'h4321, 4'b0000);
        chk("bp_no_5678", q_bcd.size(), 0);

        // simultaneous accept and reload
        bus.frame_ready = 1'b0;
        ovr0 = ovr_cnt;
        scan_frame(16'h1357);
        show(4'b0001, seg_of(4'd2), 5);
        show(4'b0010, seg_of(4'd4), 5);
        show(4'b0100, seg_of(4'd6), 5);
        show(4'b1000, seg_of(4'd8), 3);
        bus.frame_ready = 1'b1;
        show(4'b1000, seg_of(4'd8), 1);
        chk("sim_valid", bus.frame_valid, 1);
        chk("sim_bcd", bus.frame_bcd, 16'h8642);
        chk("sim_overrun", ovr_cnt - ovr0, 0);
        take_frame("sim_old", 16'h1357, 4'b0000);
        show(4'b1000, seg_of(4'd8), 1);
        chk("sim_drop", bus.frame_valid, 0);
        take_frame("sim_new", 16'h8642, 4'b0000);

        // zero and multi-hot selects never write a slot
        show(4'b0001, seg_of(4'd3), 5);
        show(4'b0010, seg_of(4'd1), 5);
        show(4'b0100, seg_of(4'd4), 5);
        show(4'b0000, seg_of(4'd8), 10);
        chk("sel0_valid", bus.frame_valid, 0);
        show(4'b0011, seg_of(4'd8), 10);
        chk("sel3_valid", bus.frame_valid, 0);
        show(4'b1000, seg_of(4'd9), 5);
        take_frame("badsel", 16'h9413, 4'b0000);

        // reset mid-handshake and mid-frame
        bus.frame_ready = 1'b0;
        scan_frame(16'h2468);
        show(4'b0001, seg_of(4'd1), 5);
        show(4'b0010, seg_of(4'd1), 5);
        show(4'b0100, seg_of(4'd1), 5);
        chk("pre_rst_valid", bus.frame_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.frame_valid, 0);
        chk("arst_bcd", bus.frame_bcd, 0);
        chk("arst_err", bus.frame_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.frame_ready = 1'b1;
        show(4'b1000, seg_of(4'd1), 6);
        chk("partial_discarded", bus.frame_valid, 0);
        chk("no_frames_left", q_bcd.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Reads back a time-multiplexed 7-segment display bus (segment pattern plus one-hot digit select) and reconstructs the BCD digits it shows. It is the inverse of the stopwatch's BCD-to-segment encoding and uses the same A..G pattern table. It sits beside the display driver as a self-check and readback path. It filters scan glitches, decodes each stable digit, assembles a complete frame of `NDIGITS` digits and hands it off on a valid/ready interface.

## Interface
- `NDIGITS`, default 4: number of multiplexed digits/slots.
- `STABLE_CYCLES`, default 4 (legal ≥2): consecutive identical samples required before a digit is accepted.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `seg_in`  in  7  segment pattern, bit6=A … bit0=G, active-high.
- `dig_sel`  in  NDIGITS  digit select, one-hot; bit i = slot i.
- `frame_bcd`  out  4*NDIGITS  slot i at [4i+3:4i].
- `frame_err`  out  NDIGITS  bit i set = slot i held an undecodable pattern.
- `frame_valid`  out  1  frame available.
- `frame_ready`  in  1  consumer accepts frame.
- `overrun`  out  1  one-cycle pulse: completed frame dropped.

## Operation
- Input stage: `seg_in`/`dig_sel` registered once (sample regs). Stability counter `cnt` (width clog2(STABLE_CYCLES)+1):
  - Sample differs from previous sample → `cnt`=0.
  - Sample equal → `cnt` increments, saturating at STABLE_CYCLES-1.
- Capture event: exactly one, in the cycle `cnt` goes from STABLE_CYCLES-2 to STABLE_CYCLES-1, and only if the sampled `dig_sel` is one-hot. `dig_sel` of zero or multi-hot is never captured; `cnt` still tracks it.
- Decode table (pattern→digit): 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1110011→9.
  - Any other pattern → nibble 4'hF, err=1.
  - Decoded patterns have err=0.
- Assembly: capture writes nibble and err into work slot i and sets `mask[i]`.
  - Re-capture of an already-set slot overwrites it (latest wins).
- Frame complete when `mask` becomes all-ones, including that cycle's write. On completion, `mask` clears next edge.
- Output register, two states: EMPTY (`frame_valid`=0), FULL (`frame_valid`=1).
  - EMPTY + complete → load work slots into `frame_bcd`/`frame_err`; go FULL.
  - FULL + `frame_ready` → transfer. If complete the same cycle, load new frame and stay FULL; else go EMPTY.
  - FULL + !`frame_ready` + complete → new frame dropped; `overrun`=1 for one cycle. Outputs unchanged.
  - `frame_bcd`/`frame_err` never change while FULL and not accepted.
- Reset (any time, including mid-frame or mid-handshake): sample regs, `cnt`, `mask`, work slots all 0. State EMPTY. Partial frame discarded.

## Timing
- Reset values: `frame_bcd`=0, `frame_err`=0, `frame_valid`=0, `overrun`=0.
- Input held constant from being sampled at edge k: capture written at edge k+STABLE_CYCLES-1.
- If that capture completes a frame while EMPTY: `frame_valid`=1 after edge k+STABLE_CYCLES-1.
- A pattern held for fewer than STABLE_CYCLES samples is never captured.
- A pattern held indefinitely is captured once. A new capture requires a change then a new stable window.
- Transfer occurs on the edge where `frame_valid`&&`frame_ready`. `frame_valid` may drop the following cycle.
- `overrun` is registered, high for exactly one cycle per dropped frame.
- No combinational path from `frame_ready` to any output.

## Test plan
- Reset: assert `rst_n`=0 mid-activity → all outputs 0 asynchronously. After release with no input → `frame_valid` stays 0.
- Clean scan, STABLE_CYCLES=4, `frame_ready`=1:
  - Stimulus: `dig_sel`=0001/0010/0100/1000 with patterns 0110000/1101101/1111001/0110011, 5 cycles each.
  - Required: `frame_bcd`=16'h4321, `frame_err`=0, `frame_valid` high 1 cycle.
- Glitch rejection: insert 1011111 on `dig_sel`=0001 for 3 cycles, then 1111110 for 5 cycles, within a scan → slot0=0 (the 6 is never captured).
- Invalid pattern: slot2 shows 0000001 in an otherwise valid frame 9,8,x,5 → `frame_bcd`=16'h5F89, `frame_err`=4'b0100.
- Backpressure: `frame_ready`=0 while two full frames (1234 then 5678) complete.
  - Required: outputs hold 16'h4321, `overrun` pulses once. After `frame_ready`=1 → accepted; no 5678 frame delivered.
- Simultaneous: `frame_ready`=1 in the cycle a new frame completes while FULL → old transferred, new loaded, `frame_valid` stays 1, `overrun`=0.
- `dig_sel`=0000 or 0011 held 10 cycles → no slot written, `mask` unchanged.
